// File: rtl/dbus_pkg.sv
// Shared constants and helpers for the data-bus MMIO responder:
// MMIO register offsets, STATUS bit positions and the byte-strobe merge.
package dbus_pkg;

  localparam logic [31:0] TXDATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS   = 32'h0000_0004;
  localparam logic [31:0] MTIME_LO_OFS = 32'h0000_0008;
  localparam logic [31:0] MTIME_HI_OFS = 32'h0000_000C;
  localparam logic [31:0] HALT_OFS     = 32'h0000_0010;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;

  // Lanes with a set strobe take the new byte, the rest keep the old one.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dbus_mmio_responder_tx_fifo.sv
// Console TX byte FIFO; a push while full is accepted only alongside a pop.
module tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // When full, the slot being popped is refilled on the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? 8'h00 : data_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) data_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dbus_mmio_responder.sv
// Data-bus responder: byte-strobed word RAM plus MMIO (TX FIFO, timer, halt).
// Define DBUS_MMIO_TIMER_EN to include the 64-bit free-running timer.
module dbus_mmio_responder
  import dbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic          is_mmio, wr, wr_mmio;
  logic [31:0]   ofs;
  logic [AW-1:0] widx;
  logic          push, pop, fifo_full, fifo_empty;
  logic          overflow_q, overflow_d;
  logic          halt_q, halt_d;
  logic [31:0]   halt_code_q, halt_code_d;
  logic [63:0]   mtime;
  logic [31:0]   status, mmio_rdata;

  assign is_mmio = (d_addr >= MMIO_BASE);
  assign ofs     = (d_addr - MMIO_BASE) & 32'hFFFF_FFFC;
  assign widx    = d_addr[2 +: AW];
  assign wr      = (d_wstrb != 4'b0000);
  assign wr_mmio = wr && is_mmio;

  always_ff @(posedge clk) begin
    if (wr && !is_mmio) mem[widx] <= strb_merge(mem[widx], d_wdata, d_wstrb);
  end

  assign push     = wr_mmio && (ofs == TXDATA_OFS) && d_wstrb[0];
  assign pop      = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (d_wdata[7:0]),
    .head_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    overflow_d  = overflow_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    if (wr_mmio && (ofs == STATUS_OFS)) overflow_d = 1'b0;
    else if (push && fifo_full && !pop) overflow_d = 1'b1;
    if (wr_mmio && (ofs == HALT_OFS) && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = strb_merge(32'h0, d_wdata, d_wstrb);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= 32'h0;
    end else begin
      overflow_q  <= overflow_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign halt      = halt_q;
  assign halt_code = halt_code_q;

`ifdef DBUS_MMIO_TIMER_EN
  logic [63:0] mtime_q, mtime_d;
  logic        wr_lo, wr_hi;

  assign wr_lo = wr_mmio && (ofs == MTIME_LO_OFS);
  assign wr_hi = wr_mmio && (ofs == MTIME_HI_OFS);

  // A written half is loaded as-is; the increment is skipped that cycle.
  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (wr_lo)      mtime_d = {mtime_q[63:32], strb_merge(mtime_q[31:0], d_wdata, d_wstrb)};
    else if (wr_hi) mtime_d = {strb_merge(mtime_q[63:32], d_wdata, d_wstrb), mtime_q[31:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mtime_q <= 64'h0;
    else        mtime_q <= mtime_d;
  end

  assign mtime = mtime_q;
`else
  assign mtime = 64'h0;
`endif

  always_comb begin
    status                   = 32'h0;
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[STATUS_OVF_BIT]   = overflow_q;
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (ofs)
      STATUS_OFS:   mmio_rdata = status;
      MTIME_LO_OFS: mmio_rdata = mtime[31:0];
      MTIME_HI_OFS: mmio_rdata = mtime[63:32];
      HALT_OFS:     mmio_rdata = halt_code_q;
      default:      mmio_rdata = 32'h0;
    endcase
  end

  assign d_rdata = is_mmio ? mmio_rdata : mem[widx];

endmodule

// File: doc/dbus_mmio_responder.md
# dbus_mmio_responder

Responder end of the core's data bus (`d_addr`/`d_wdata`/`d_wstrb`/`d_rdata`): serves loads and stores from the RISC-V core. Decodes each access into one of two regions: a byte-strobed word RAM, or a small MMIO register block. The MMIO block holds a buffered console TX FIFO, a free-running 64-bit timer and a sticky halt/exit register. Sits beside the core at the top level, replacing the plain data memory in system-level benches.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'h8000_0000: first MMIO byte address. Addresses ≥ base go to MMIO; all others go to RAM.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `d_addr` in 32: byte address; bits [1:0] ignored.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: byte write enables; `4'b0000` means a read-only cycle.
- `d_rdata` out 32: load data, combinational from `d_addr`.
- `tx_data` out 8: FIFO head byte; 0 when the FIFO is empty.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: sink accepts the head byte.
- `halt` out 1: sticky; set by a write to HALT.
- `halt_code` out 32: value captured by the first HALT write.

## Operation
- **RAM**
  - Array named `mem`, word index `d_addr[2 +: $clog2(MEM_WORDS)]`; higher bits alias.
  - Each set `d_wstrb[i]` writes byte lane i. RAM is not reset.
- **MMIO offsets** (relative to `MMIO_BASE`):
  - 0x00 TXDATA: write with `d_wstrb[0]`=1 pushes `d_wdata[7:0]`; other strobes are ignored; reads 0.
  - 0x04 STATUS: reads `{29'b0, overflow, full, empty}`; any write (any strobe) clears `overflow`.
  - 0x08 MTIME_LO and 0x0C MTIME_HI: the timer halves, byte-strobe writable.
  - 0x10 HALT: first write sets `halt`=1 and `halt_code` = strobe-merge of `d_wdata` over 0; later writes are ignored. Reads `halt_code`.
  - Any other offset: reads 0, writes ignored.
- **FIFO**
  - Pop on `tx_valid && tx_ready`.
  - Push when not full; a push while full with a simultaneous pop is accepted (count unchanged).
  - A push while full without a pop is dropped and sets sticky `overflow`.
  - Pointers wrap modulo `FIFO_DEPTH`; the count needs $clog2(FIFO_DEPTH)+1 bits.
- **Timer**
  - Increments by 1 every cycle, wrapping at 2^64.
  - In a cycle that writes either half, the counter loads the merged value (written lanes new, all others old) and does not increment that cycle.

## Timing
- Reads are zero-latency combinational and reflect state before the current edge. A same-cycle write then read of one address returns the old value.
- Writes commit at the rising edge on which `d_wstrb` ≠ 0.
- A pushed byte appears on `tx_data`/`tx_valid` one edge after the push, if the FIFO was empty.
- Reset (`reset` low) asynchronously forces all of the following, regardless of in-flight pushes or pops:
  - FIFO empty, `overflow`=0, `tx_valid`=0, `tx_data`=0;
  - timer=0;
  - `halt`=0, `halt_code`=0.
- The timer reads 0 in the first cycle after reset release and increments thereafter.

## Configuration
- `DBUS_MMIO_TIMER_EN`
  - Defined: the 64-bit timer is present as described.
  - Undefined: no timer flops; MTIME_LO/HI read 0 and writes to them are ignored. All other behaviour is unchanged.

## Structure
- `dbus_pkg` holds: the MMIO offset constants (`TXDATA_OFS`, `STATUS_OFS`, `MTIME_LO_OFS`, `MTIME_HI_OFS`, `HALT_OFS`), the STATUS bit positions, and a byte-strobe merge function shared by RAM, timer and HALT.
- One sub-module, `tx_fifo` (parameter DEPTH, 8-bit data), provides push, pop, full, empty and the read head. The push-while-full rule (accept on simultaneous pop) lives inside it.

## Test plan
- RAM strobes: write 0x11223344 with strobe 1111 at 0x10, then 0xAABBCCDD with strobe 0101 → read at 0x10 returns 0x11BB33DD.
- FIFO drain:
  - With `tx_ready`=0, write 0x41 then 0x42 to TXDATA → STATUS=0x0, `tx_valid`=1, `tx_data`=0x41.
  - Raise `tx_ready` for 2 cycles → bytes 0x41, 0x42 delivered in order, then STATUS=0x1.
- Overflow: with `tx_ready`=0, write 9 bytes at depth 8 → STATUS=0x6; write STATUS → STATUS=0x2. Drain → exactly the first 8 bytes appear.
- Timer (macro defined):
  - Write MTIME_HI=1 and MTIME_LO=0xFFFFFFFF in consecutive cycles.
  - One cycle after the LO write → {HI,LO}={1,0xFFFFFFFF}; one cycle later → {2,0}.
  - Undefined build: reads stay 0.
- Halt: write 0x0000_0001 to HALT → `halt`=1, `halt_code`=1 after the edge. Then write 0x5 → `halt_code` still 1.
- Reset mid-operation: queue 3 bytes, pull `reset` low between clock edges → `tx_valid`=0, `halt`=0 and STATUS=0x1 immediately; a RAM word written earlier keeps its value.
